// File: rtl/pa_f_spsram_cfg_pkg.sv
// Shared definitions for the configurable single-port SRAM: clear-engine
// state encoding and write-lane count derivation.
package pa_f_spsram_cfg_pkg;

    // Clear-engine states; encoding is fixed so debug probes can decode it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Number of byte-style write lanes in one word.
    function automatic int calc_lanes(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

endpackage

// File: rtl/pa_f_spsram_cfg_core.sv
// Plain inferred single-port RAM: per-lane write enable and a registered
// synchronous read port whose output holds between reads.
module pa_f_spsram_cfg_core
    import pa_f_spsram_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         we_i,
    input  logic [calc_lanes(DATA_WIDTH, LANE_WIDTH)-1:0] lane_we_i,
    input  logic [ADDR_WIDTH-1:0]                        addr_i,
    input  logic [DATA_WIDTH-1:0]                        wdata_i,
    input  logic                                         re_i,
    output logic [DATA_WIDTH-1:0]                        rdata_o
);
    localparam int LANES = calc_lanes(DATA_WIDTH, LANE_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array write: each enabled lane takes its slice of the write data.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_we_i[l]) begin
                    mem_q[addr_i][l*LANE_WIDTH +: LANE_WIDTH] <= wdata_i[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Read register: only a read cycle loads it, so writes never disturb it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pa_f_spsram_cfg.sv
// Configurable single-port synchronous SRAM for FPGA builds: lane writes,
// optional output register, hardware clear engine and read-data hold.
module pa_f_spsram_cfg
    import pa_f_spsram_cfg_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LANE_WIDTH = 8,
    parameter int                    OUT_REG    = 0,
    parameter int                    INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                                         CLK,
    input  logic                                         RST,
    input  logic [ADDR_WIDTH-1:0]                        A,
    input  logic                                         CEN,
    input  logic                                         GWEN,
    input  logic [calc_lanes(DATA_WIDTH, LANE_WIDTH)-1:0] WEN,
    input  logic [DATA_WIDTH-1:0]                        D,
    output logic [DATA_WIDTH-1:0]                        Q,
    input  logic                                         INIT_REQ,
    output logic                                         INIT_BUSY
);
    localparam int LANES = calc_lanes(DATA_WIDTH, LANE_WIDTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  boot_q, boot_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] addr_hold_q;

    logic                  func_acc;
    logic                  func_rd;
    logic                  func_wr;
    logic                  clr_wr;
    logic                  mem_we;
    logic [LANES-1:0]      mem_lane;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Port arbitration: the clear engine owns the array while busy; an
    // all-lanes-masked write is dropped so it cannot touch the array.
    always_comb begin
        func_acc  = ~busy_q & ~CEN;
        func_rd   = func_acc & GWEN;
        func_wr   = func_acc & ~GWEN & ~(&WEN);
        clr_wr    = (state_q == ST_CLEAR);
        mem_we    = clr_wr | func_wr;
        mem_lane  = clr_wr ? {LANES{1'b1}} : ~WEN;
        mem_addr  = clr_wr ? clr_addr_q : (func_acc ? A : addr_hold_q);
        mem_wdata = clr_wr ? INIT_VAL : D;
    end

    // Clear FSM next state: a pending boot clear or a request starts a pass,
    // one word per cycle, then a single DONE cycle rewinds the counter.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        boot_d     = boot_q;
        case (state_q)
            ST_IDLE: begin
                if (boot_q || INIT_REQ) begin
                    state_d = ST_CLEAR;
                    boot_d  = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_DONE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                clr_addr_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                clr_addr_d = '0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR) || (state_d == ST_DONE);
    end

    // Clear FSM state; the boot flag arms an automatic pass after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            boot_q     <= (INIT_EN != 0);
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            boot_q     <= boot_d;
            busy_q     <= busy_d;
        end
    end

    // Hold the last accepted address so the array address is quiet while deselected.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_hold_q <= '0;
        end else if (func_acc) begin
            addr_hold_q <= A;
        end
    end

    pa_f_spsram_cfg_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_WIDTH (LANE_WIDTH)
    ) u_core (
        .clk_i     (CLK),
        .rst_i     (RST),
        .we_i      (mem_we),
        .lane_we_i (mem_lane),
        .addr_i    (mem_addr),
        .wdata_i   (mem_wdata),
        .re_i      (func_rd),
        .rdata_o   (mem_rdata)
    );

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  vld_q;
            logic [DATA_WIDTH-1:0] q_q;

            // Second stage loads only one cycle after a read, otherwise holds.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    vld_q <= 1'b0;
                    q_q   <= '0;
                end else begin
                    vld_q <= func_rd;
                    if (vld_q) begin
                        q_q <= mem_rdata;
                    end
                end
            end

            assign Q = q_q;
        end else begin : g_no_out_reg
            assign Q = mem_rdata;
        end
    endgenerate

    assign INIT_BUSY = busy_q;

endmodule
